// File: rtl/alu_bist_sequencer.sv
// -----------------------------------------------------------------------------
// alu_bist_sequencer
//   Built-in self-test driver for the 8-bit ALU (A, B, SL -> Su, C, Z, S, P).
//   A run steps all 16 opcodes over VECTORS pseudo-random operand pairs. Each
//   ALU response is folded into a 12-bit MISR. At the end the signature is
//   compared with a golden value.
//
//   Handshake: start is a level sampled only in IDLE. A run then owns the ALU
//   until the one-cycle done pulse. busy covers the accept edge through the
//   DONE cycle. abort wins over start and cancels WAIT/CAPTURE, but not DONE.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, abort        run request / synchronous abandon
//   sig_expected[11:0]  golden signature
//   alu_su[7:0], alu_c, alu_z, alu_s, alu_p   ALU response under test
//   alu_a[7:0], alu_b[7:0], alu_sl[3:0]       registered ALU stimulus
//   busy, done, pass    run status (done is a one-cycle pulse)
//   signature[11:0]     live MISR value, final while done=1
//   dbg_state[1:0]      FSM state, for checkers (0 IDLE,1 WAIT,2 CAPTURE,3 DONE)
// -----------------------------------------------------------------------------
module alu_bist_sequencer #(
  parameter int unsigned VECTORS = 16,
  parameter int unsigned SETTLE  = 1,
  parameter logic [7:0]  SEED_A  = 8'h93,
  parameter logic [7:0]  SEED_B  = 8'h02
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [11:0] sig_expected,
  input  logic [7:0]  alu_su,
  input  logic        alu_c,
  input  logic        alu_z,
  input  logic        alu_s,
  input  logic        alu_p,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_sl,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [11:0] signature,
  output logic [1:0]  dbg_state
);

  // Index of the final capture: VECTORS pairs times 16 opcodes, minus one.
  localparam logic [11:0] LAST_CAP  = 12'(VECTORS * 16 - 1);
  localparam logic [3:0]  WAIT_INIT = 4'(SETTLE - 1);

  if (VECTORS == 0 || VECTORS > 255) begin : g_bad_vectors
    $error("alu_bist_sequencer: VECTORS=%0d outside 1..255", VECTORS);
  end
  if (SETTLE == 0 || SETTLE > 15) begin : g_bad_settle
    $error("alu_bist_sequencer: SETTLE=%0d outside 1..15", SETTLE);
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  wcnt;
  logic [11:0] cap_cnt;
  logic [11:0] cap_data;

  // Operand generator: taps 7,5,4,3. A zero seed is a fixed point.
  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  // Signature compactor: shift with feedback from taps 11,5,3,0, then fold in d.
  function automatic logic [11:0] misr_next(input logic [11:0] m, input logic [11:0] d);
    return {m[10:0], m[11] ^ m[5] ^ m[3] ^ m[0]} ^ d;
  endfunction

  assign cap_data  = {alu_su, alu_c, alu_z, alu_s, alu_p};
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wcnt      <= 4'd0;
      cap_cnt   <= 12'd0;
      alu_a     <= 8'd0;
      alu_b     <= 8'd0;
      alu_sl    <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= 12'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (abort) begin
            pass <= 1'b0;
          end else if (start) begin
            alu_a     <= SEED_A;
            alu_b     <= SEED_B;
            alu_sl    <= 4'd0;
            signature <= 12'd0;
            pass      <= 1'b0;
            wcnt      <= WAIT_INIT;
            cap_cnt   <= 12'd0;
            busy      <= 1'b1;
            state     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (abort) begin
            busy  <= 1'b0;
            pass  <= 1'b0;
            state <= ST_IDLE;
          end else if (wcnt == 4'd0) begin
            state <= ST_CAPTURE;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end

        ST_CAPTURE: begin
          if (abort) begin
            // Abandon without folding in this response; signature holds.
            busy  <= 1'b0;
            pass  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            signature <= misr_next(signature, cap_data);
            if (cap_cnt == LAST_CAP) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              cap_cnt <= cap_cnt + 12'd1;
              alu_sl  <= alu_sl + 4'd1;
              // Opcode wrap 15->0 marks the next operand pair.
              if (alu_sl == 4'd15) begin
                alu_a <= lfsr_next(alu_a);
                alu_b <= lfsr_next(alu_b);
              end
              wcnt  <= WAIT_INIT;
              state <= ST_WAIT;
            end
          end
        end

        ST_DONE: begin
          // abort is deliberately ignored here: the run completes.
          pass  <= (signature == sig_expected);
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_bist_sequencer
//   Two sequencers (VECTORS=16/SETTLE=1 and VECTORS=1/SETTLE=3), each with a
//   stub ALU on its alu_* inputs. A run-level model predicts, for every cycle
//   after a start is accepted, what the outputs must be from capture arithmetic
//   (captures done = offset/(SETTLE+1)); directed checks pin literal values.
// -----------------------------------------------------------------------------
module tb_alu_bist_sequencer;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals (index 0 = big, 1 = small) ----------------
  logic        start_v [2];
  logic        abort_v [2];
  logic [11:0] sig_exp [2];
  logic [11:0] st_d    [2];
  logic [7:0]  d_a     [2];
  logic [7:0]  d_b     [2];
  logic [3:0]  d_sl    [2];
  logic        d_busy  [2];
  logic        d_done  [2];
  logic        d_pass  [2];
  logic [11:0] d_sig   [2];
  logic [1:0]  d_state [2];
  int          stub_mode = 0;

  int n_checks = 0;
  int n_errors = 0;

  alu_bist_sequencer #(.VECTORS(16), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .sig_expected(sig_exp[0]),
    .alu_su(st_d[0][11:4]), .alu_c(st_d[0][3]), .alu_z(st_d[0][2]),
    .alu_s(st_d[0][1]), .alu_p(st_d[0][0]),
    .alu_a(d_a[0]), .alu_b(d_b[0]), .alu_sl(d_sl[0]),
    .busy(d_busy[0]), .done(d_done[0]), .pass(d_pass[0]),
    .signature(d_sig[0]), .dbg_state(d_state[0])
  );

  alu_bist_sequencer #(.VECTORS(1), .SETTLE(3)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .sig_expected(sig_exp[1]),
    .alu_su(st_d[1][11:4]), .alu_c(st_d[1][3]), .alu_z(st_d[1][2]),
    .alu_s(st_d[1][1]), .alu_p(st_d[1][0]),
    .alu_a(d_a[1]), .alu_b(d_b[1]), .alu_sl(d_sl[1]),
    .busy(d_busy[1]), .done(d_done[1]), .pass(d_pass[1]),
    .signature(d_sig[1]), .dbg_state(d_state[1])
  );

  // ---------------- stub ALU: response packed as {su, c, z, s, p} ----------------
  function automatic logic [11:0] stub_resp(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] sl, input int mode);
    logic [7:0] su;
    su = (a ^ b) + {4'h0, sl};
    if (mode == 1) return 12'h010;
    if (mode == 2) return 12'h000;
    return {su, a[0] ^ sl[0], su == 8'h00, su[7], ^su};
  endfunction

  assign st_d[0] = stub_resp(d_a[0], d_b[0], d_sl[0], stub_mode);
  assign st_d[1] = stub_resp(d_a[1], d_b[1], d_sl[1], stub_mode);

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int n_of(input int i);
    return (i == 0) ? 256 : 16;
  endfunction
  function automatic int s_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return 8'((x << 1) | {7'd0, ^(x & 8'hB8)});
  endfunction

  function automatic logic [11:0] misr_step(input logic [11:0] m, input logic [11:0] d);
    return 12'(((m << 1) | {11'd0, ^(m & 12'h829)}) ^ d);
  endfunction

  logic [11:0] sig_tab [2][0:256];  // signature after k captures
  logic [7:0]  op_a    [2][0:255];  // operands presented for capture k
  logic [7:0]  op_b    [2][0:255];
  logic [3:0]  op_sl   [2][0:255];
  bit          m_active [2];
  int          m_off    [2];        // cycles since the accept edge
  logic        m_pass   [2];
  logic [11:0] m_isig   [2];        // values held while idle
  logic [7:0]  m_ha     [2];
  logic [7:0]  m_hb     [2];
  logic [3:0]  m_hsl    [2];

  // Scoreboard of final signatures expected at each done pulse.
  logic [11:0] exp_q0[$];
  logic [11:0] exp_q1[$];

  task automatic build_tab(input int i);
    logic [7:0]  a;
    logic [7:0]  b;
    logic [11:0] m;
    a = 8'h93;
    b = 8'h02;
    m = 12'h000;
    sig_tab[i][0] = m;
    for (int k = 0; k < n_of(i); k++) begin
      op_a[i][k]  = a;
      op_b[i][k]  = b;
      op_sl[i][k] = 4'(k % 16);
      m = misr_step(m, stub_resp(a, b, 4'(k % 16), stub_mode));
      sig_tab[i][k+1] = m;
      if (k % 16 == 15) begin
        a = lfsr_step(a);
        b = lfsr_step(b);
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0;
      m_off[i]    = 0;
      m_pass[i]   = 1'b0;
      m_isig[i]   = 12'h000;
      m_ha[i]     = 8'h00;
      m_hb[i]     = 8'h00;
      m_hsl[i]    = 4'h0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic model_hold(input int i, input int c, input logic [11:0] s);
    m_isig[i] = s;
    m_ha[i]   = op_a[i][c];
    m_hb[i]   = op_b[i][c];
    m_hsl[i]  = op_sl[i][c];
  endtask

  task automatic model_step(input int i);
    int n;
    int c;
    n = n_of(i);
    if (m_active[i]) begin
      c = m_off[i] / (s_of(i) + 1);
      if (m_off[i] == n * (s_of(i) + 1)) begin
        m_active[i] = 1'b0;
        m_pass[i]   = (sig_tab[i][n] == sig_exp[i]);
        model_hold(i, n - 1, sig_tab[i][n]);
      end else if (abort_v[i]) begin
        m_active[i] = 1'b0;
        m_pass[i]   = 1'b0;
        model_hold(i, c, sig_tab[i][c]);
        if (i == 0) void'(exp_q0.pop_back()); else void'(exp_q1.pop_back());
      end else begin
        m_off[i]++;
      end
    end else if (abort_v[i]) begin
      m_pass[i] = 1'b0;
    end else if (start_v[i]) begin
      build_tab(i);
      m_active[i] = 1'b1;
      m_off[i]    = 0;
      m_pass[i]   = 1'b0;
      if (i == 0) exp_q0.push_back(sig_tab[i][n]); else exp_q1.push_back(sig_tab[i][n]);
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_clear();
      else for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // ---------------- compare process (every negedge, both instances) ----------------
  task automatic compare_outputs(input int i);
    int          n;
    int          c;
    logic        e_busy;
    logic        e_done;
    logic        e_pass;
    logic [11:0] e_sig;
    logic [7:0]  e_a;
    logic [7:0]  e_b;
    logic [3:0]  e_sl;
    n = n_of(i);
    if (m_active[i]) begin
      e_busy = 1'b1;
      e_pass = 1'b0;
      if (m_off[i] == n * (s_of(i) + 1)) begin
        e_done = 1'b1;
        c      = n - 1;
        e_sig  = sig_tab[i][n];
      end else begin
        e_done = 1'b0;
        c      = m_off[i] / (s_of(i) + 1);
        e_sig  = sig_tab[i][c];
      end
      e_a  = op_a[i][c];
      e_b  = op_b[i][c];
      e_sl = op_sl[i][c];
    end else begin
      e_busy = 1'b0;
      e_done = 1'b0;
      e_pass = m_pass[i];
      e_sig  = m_isig[i];
      e_a    = m_ha[i];
      e_b    = m_hb[i];
      e_sl   = m_hsl[i];
    end
    chk("busy", i, d_busy[i], e_busy);
    chk("done", i, d_done[i], e_done);
    chk("pass", i, d_pass[i], e_pass);
    chk("signature", i, d_sig[i], e_sig);
    chk("alu_a", i, d_a[i], e_a);
    chk("alu_b", i, d_b[i], e_b);
    chk("alu_sl", i, d_sl[i], e_sl);
    if (d_done[i]) begin
      if (i == 0 && exp_q0.size() > 0)      chk("sb_final_sig", i, d_sig[i], exp_q0.pop_front());
      else if (i == 1 && exp_q1.size() > 0) chk("sb_final_sig", i, d_sig[i], exp_q1.pop_front());
      else                                  chk("sb_unexpected_done", i, d_done[i], 1'b0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) compare_outputs(i);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input int i);
    start_v[i] = 1'b1;
    tick(1);
    start_v[i] = 1'b0;
  endtask

  // Returns the negedge count (0 = first cycle after call) of done, or -1.
  task automatic wait_done(input int i, input int limit, output int lat);
    lat = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (d_done[i]) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int lat;
    int dcount;
    int first_done;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
      sig_exp[i] = 12'h000;
    end

    // Reset state.
    tick(3);
    @(negedge clk);
    chk("reset_busy", 0, d_busy[0], 1'b0);
    chk("reset_sig", 0, d_sig[0], 12'h000);
    chk("reset_alu_a", 0, d_a[0], 8'h00);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // 1+2: count, busy rise, operand sequence, pass with a computed golden.
    stub_mode = 0;
    build_tab(0);
    sig_exp[0] = sig_tab[0][256];
    start_pulse(0);
    lat = -1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("s1_busy_rise", 0, d_busy[0], 1'b1);
        chk("s2_a0", 0, d_a[0], 8'h93);
        chk("s2_b0", 0, d_b[0], 8'h02);
        chk("s2_sl0", 0, d_sl[0], 4'h0);
      end
      if (k == 30) begin
        chk("s2_a15", 0, d_a[0], 8'h93);
        chk("s2_sl15", 0, d_sl[0], 4'hF);
      end
      if (k == 32) begin
        chk("s2_a16", 0, d_a[0], 8'h26);
        chk("s2_b16", 0, d_b[0], 8'h04);
        chk("s2_sl16", 0, d_sl[0], 4'h0);
      end
      if (d_done[0]) begin
        lat = k;
        break;
      end
    end
    chk("s1_latency", 0, lat, 512);
    @(negedge clk);
    chk("s1_done_width", 0, d_done[0], 1'b0);
    chk("s1_pass", 0, d_pass[0], 1'b1);
    chk("s1_busy_fall", 0, d_busy[0], 1'b0);
    tick(1);

    // 3: MISR with constant response su=0x01.
    stub_mode = 1;
    start_pulse(0);
    @(negedge clk);
    chk("s3_sig0", 0, d_sig[0], 12'h000);
    repeat (2) @(negedge clk);
    chk("s3_sig1", 0, d_sig[0], 12'h010);
    repeat (2) @(negedge clk);
    chk("s3_sig2", 0, d_sig[0], 12'h030);
    chk("s3_model_sig1", 0, sig_tab[0][1], 12'h010);
    chk("s3_model_sig2", 0, sig_tab[0][2], 12'h030);
    wait_done(0, 1000, lat);
    chk("s3_done_seen", 0, d_done[0], 1'b1);
    tick(1);

    // 4: all-zero response, golden match then mismatch.
    stub_mode  = 2;
    sig_exp[0] = 12'h000;
    start_pulse(0);
    wait_done(0, 1000, lat);
    chk("s4_final_sig", 0, d_sig[0], 12'h000);
    @(negedge clk);
    chk("s4_pass_match", 0, d_pass[0], 1'b1);
    tick(1);
    sig_exp[0] = 12'h001;
    start_pulse(0);
    wait_done(0, 1000, lat);
    @(negedge clk);
    chk("s4_pass_mismatch", 0, d_pass[0], 1'b0);
    tick(1);

    // 5: abort mid-run, abort+start in IDLE, then a clean rerun.
    stub_mode = 0;
    build_tab(0);
    sig_exp[0] = sig_tab[0][256];
    start_pulse(0);
    tick(98);
    abort_v[0] = 1'b1;
    tick(1);
    abort_v[0] = 1'b0;
    @(negedge clk);
    chk("s5_abort_busy", 0, d_busy[0], 1'b0);
    chk("s5_abort_pass", 0, d_pass[0], 1'b0);
    dcount = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (d_done[0]) dcount++;
    end
    chk("s5_no_done", 0, dcount, 0);
    tick(1);
    abort_v[0] = 1'b1;
    start_v[0] = 1'b1;
    tick(1);
    abort_v[0] = 1'b0;
    start_v[0] = 1'b0;
    @(negedge clk);
    chk("s5_abort_wins", 0, d_busy[0], 1'b0);
    tick(1);
    start_pulse(0);
    wait_done(0, 1000, lat);
    chk("s5_rerun_latency", 0, lat, 512);
    @(negedge clk);
    chk("s5_rerun_pass", 0, d_pass[0], 1'b1);
    tick(1);

    // 6: reset mid-run clears everything at once.
    start_pulse(0);
    tick(50);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_busy", 0, d_busy[0], 1'b0);
    chk("s6_rst_done", 0, d_done[0], 1'b0);
    chk("s6_rst_pass", 0, d_pass[0], 1'b0);
    chk("s6_rst_sig", 0, d_sig[0], 12'h000);
    chk("s6_rst_a", 0, d_a[0], 8'h00);
    chk("s6_rst_b", 0, d_b[0], 8'h00);
    chk("s6_rst_sl", 0, d_sl[0], 4'h0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // 6: small instance; start while busy and in DONE ignored; abort in DONE.
    build_tab(1);
    sig_exp[1] = sig_tab[1][16];
    start_pulse(1);
    dcount     = 0;
    first_done = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (d_done[1]) begin
        dcount++;
        if (first_done < 0) first_done = k;
      end
      start_v[1] = (k == 10 || k == 64);
      abort_v[1] = (k == 64);
      if (k == 65) begin
        chk("s6_small_busy_fall", 1, d_busy[1], 1'b0);
        chk("s6_small_pass", 1, d_pass[1], 1'b1);
      end
    end
    start_v[1] = 1'b0;
    abort_v[1] = 1'b0;
    chk("s6_small_latency", 1, first_done, 64);
    chk("s6_small_done_count", 1, dcount, 1);

    tick(4);
    chk("sb_drain0", 0, exp_q0.size(), 0);
    chk("sb_drain1", 1, exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
